// File: rtl/knockback_engine_pkg.sv
// knockback_pkg: shared types and constants for knockback_engine.
//   kbState   - engine FSM state (IDLE, CALC, HITSTUN, DECAY)
//   kbDir     - launch direction class of an attack
//   ATK_*     - bit positions inside the attacker's attack word
//   DMG_W / BASE_W - widths of the damage and base-knockback table fields
//   hitInfo   - decoded attack {valid, dmg, base, dir}
//   lutEntry  - attack table indexed by attack bit position
package knockback_pkg;

  typedef enum logic [1:0] {IDLE, CALC, HITSTUN, DECAY} kbState;
  typedef enum logic [2:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_FACING} kbDir;

  localparam int DMG_W  = 8;
  localparam int BASE_W = 7;

  localparam int ATK_HIT       = 0;
  localparam int ATK_SMASH_U   = 1;
  localparam int ATK_SMASH_D   = 2;
  localparam int ATK_SMASH_L   = 3;
  localparam int ATK_SMASH_R   = 4;
  localparam int ATK_JAB       = 5;
  localparam int ATK_SPECIAL_U = 6;
  localparam int ATK_SPECIAL_D = 7;
  localparam int ATK_SPECIAL_L = 8;
  localparam int ATK_SPECIAL_R = 9;
  localparam int ATK_SPECIAL_N = 10;

  typedef struct packed {
    logic              valid;
    logic [DMG_W-1:0]  dmg;
    logic [BASE_W-1:0] base;
    kbDir              dir;
  } hitInfo;

  function automatic hitInfo lutEntry(input int idx);
    hitInfo e;
    e = '0;
    e.valid = 1'b1;
    case (idx)
      ATK_SMASH_U:   begin e.dmg = 8'd15; e.base = 7'd6; e.dir = DIR_UP;     end
      ATK_SMASH_D:   begin e.dmg = 8'd14; e.base = 7'd5; e.dir = DIR_DOWN;   end
      ATK_SMASH_L:   begin e.dmg = 8'd16; e.base = 7'd6; e.dir = DIR_LEFT;   end
      ATK_SMASH_R:   begin e.dmg = 8'd16; e.base = 7'd6; e.dir = DIR_RIGHT;  end
      ATK_JAB:       begin e.dmg = 8'd3;  e.base = 7'd1; e.dir = DIR_FACING; end
      ATK_SPECIAL_U: begin e.dmg = 8'd8;  e.base = 7'd4; e.dir = DIR_UP;     end
      ATK_SPECIAL_D: begin e.dmg = 8'd10; e.base = 7'd3; e.dir = DIR_DOWN;   end
      ATK_SPECIAL_L: begin e.dmg = 8'd9;  e.base = 7'd4; e.dir = DIR_LEFT;   end
      ATK_SPECIAL_R: begin e.dmg = 8'd9;  e.base = 7'd4; e.dir = DIR_RIGHT;  end
      ATK_SPECIAL_N: begin e.dmg = 8'd6;  e.base = 7'd2; e.dir = DIR_FACING; end
      default:       e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/knockback_engine_lut.sv
// attack_lut: combinational priority encoder + attack table.
//   attackBits in  [10:1] attack type bits
//   info       out hitInfo {valid, dmg, base, dir}; valid=0 when no type bit set
// Lowest set bit index wins.
module attack_lut
  import knockback_pkg::*;
(
  input  logic [ATK_SPECIAL_N:ATK_SMASH_U] attackBits,
  output hitInfo                           info
);

  // Scan high to low so the lowest set index is the last (winning) write.
  always_comb begin
    info = '0;
    for (int i = ATK_SPECIAL_N; i >= ATK_SMASH_U; i--)
      if (attackBits[i]) info = lutEntry(i);
  end

endmodule

// File: rtl/knockback_engine.sv
// knockback_engine: detects hits on the victim, accumulates damage percent,
// computes a launch velocity and times hitstun / velocity decay on a frame tick.
//   clock           in  system clock
//   reset           in  async active-low reset
//   attack          in  [31:0] attack word (bit0 any hit, bits10:1 type)
//   attacker_facing in  1 = attacker faces right
//   clear_damage    in  KO / stock reset, synchronous, beats a hit
//   damage          out [15:0] damage percent
//   knock_vel       out [31:0] {vx, vy}, two's complement px/frame, +Y up
//   hitstun         out high in CALC/HITSTUN
//   hit_ack         out one-cycle pulse per accepted hit
// Build option: KNOCKBACK_SCALE_EN adds (damage >> 4) to the launch magnitude.
module knockback_engine
  import knockback_pkg::*;
#(
  parameter int FRAME_DIV      = 833333,
  parameter int HITSTUN_FRAMES = 12,
  parameter int DAMAGE_MAX     = 999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] attack,
  input  logic        attacker_facing,
  input  logic        clear_damage,
  output logic [15:0] damage,
  output logic [31:0] knock_vel,
  output logic        hitstun,
  output logic        hit_ack
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int HS_W  = $clog2(HITSTUN_FRAMES + 1);

  kbState             state, stateNext;
  hitInfo             hitLut;
  logic               attack0Q, hitEdge, acceptHit, frameTick;
  logic [DIV_W-1:0]   divCnt;
  logic [HS_W-1:0]    frameCnt;
  logic [BASE_W-1:0]  baseQ;
  kbDir               dirQ;
  logic               facingQ;
  logic [15:0]        velX, velY, launchX, launchY, stepX, stepY, mag;
  logic [16:0]        magWide, dmgSum;
  logic               velZero, stepZero;
  logic               unusedAttack;

  assign unusedAttack = ^attack[31:ATK_SPECIAL_N+1];

  attack_lut uLut (
    .attackBits (attack[ATK_SPECIAL_N:ATK_SMASH_U]),
    .info       (hitLut)
  );

  assign hitEdge   = attack[ATK_HIT] & ~attack0Q;
  assign acceptHit = hitEdge & hitLut.valid;
  assign frameTick = (divCnt == DIV_W'(FRAME_DIV - 1));

  // Launch magnitude from the latched attack; damage already holds the
  // post-hit value while in CALC.
`ifdef KNOCKBACK_SCALE_EN
  assign magWide = 17'(baseQ) + 17'(damage >> 4);
`else
  assign magWide = 17'(baseQ);
`endif
  assign mag    = (magWide > 17'd127) ? 16'd127 : magWide[15:0];
  assign dmgSum = 17'(damage) + 17'(hitLut.dmg);

  always_comb begin
    launchX = '0;
    launchY = '0;
    case (dirQ)
      DIR_UP:     launchY = mag;
      DIR_DOWN:   launchY = -mag;
      DIR_LEFT:   launchX = -mag;
      DIR_RIGHT:  launchX = mag;
      DIR_FACING: begin
        launchX = facingQ ? mag : -mag;
        launchY = mag >> 1;
      end
      default: ;
    endcase
  end

  // One step toward zero per component (sign bit picks the direction).
  assign stepX    = (velX == '0) ? '0 : (velX[15] ? velX + 16'd1 : velX - 16'd1);
  assign stepY    = (velY == '0) ? '0 : (velY[15] ? velY + 16'd1 : velY - 16'd1);
  assign velZero  = (velX == '0) && (velY == '0);
  assign stepZero = (stepX == '0) && (stepY == '0);

  // FSM: state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= stateNext;

  // FSM: next state
  always_comb begin
    stateNext = state;
    if (clear_damage) stateNext = IDLE;
    else begin
      case (state)
        IDLE:    if (acceptHit) stateNext = CALC;
        CALC:    stateNext = HITSTUN;
        HITSTUN: if (frameTick && frameCnt == HS_W'(HITSTUN_FRAMES - 1)) stateNext = DECAY;
        DECAY: begin
          if (acceptHit)                          stateNext = CALC;
          else if (velZero || (frameTick && stepZero)) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    hitstun   = (state == CALC) || (state == HITSTUN);
    hit_ack   = (state == CALC);
    knock_vel = (state == IDLE) ? 32'd0 : {velX, velY};
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) divCnt <= '0;
    else if (frameTick) divCnt <= '0;
    else divCnt <= divCnt + 1'b1;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      attack0Q <= 1'b0;
      damage   <= '0;
      baseQ    <= '0;
      dirQ     <= DIR_UP;
      facingQ  <= 1'b0;
      frameCnt <= '0;
      velX     <= '0;
      velY     <= '0;
    end else begin
      attack0Q <= attack[ATK_HIT];
      if (clear_damage) damage <= '0;
      else if (stateNext == CALC)
        damage <= (dmgSum > 17'(DAMAGE_MAX)) ? 16'(DAMAGE_MAX) : dmgSum[15:0];
      if (stateNext == CALC) begin
        baseQ   <= hitLut.base;
        dirQ    <= hitLut.dir;
        facingQ <= attacker_facing;
      end
      if (state == CALC) frameCnt <= '0;
      else if (state == HITSTUN && frameTick) frameCnt <= frameCnt + 1'b1;
      if (clear_damage) begin
        velX <= '0;
        velY <= '0;
      end else if (state == CALC) begin
        velX <= launchX;
        velY <= launchY;
      end else if (state == DECAY && frameTick) begin
        velX <= stepX;
        velY <= stepY;
      end
    end

endmodule

// File: tb/tb_knockback_engine.sv
module tb_knockback_engine;

  localparam int FD   = 4;
  localparam int HF   = 2;
  localparam int DMAX = 999;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] attack = '0;
  logic        attacker_facing = 1'b0;
  logic        clear_damage = 1'b0;
  logic [15:0] damage;
  logic [31:0] knock_vel;
  logic        hitstun, hit_ack;

  knockback_engine #(.FRAME_DIV(FD), .HITSTUN_FRAMES(HF), .DAMAGE_MAX(DMAX)) dut (
    .clock           (clock),
    .reset           (reset),
    .attack          (attack),
    .attacker_facing (attacker_facing),
    .clear_damage    (clear_damage),
    .damage          (damage),
    .knock_vel       (knock_vel),
    .hitstun         (hitstun),
    .hit_ack         (hit_ack)
  );

  always #5 clock = ~clock;

  typedef struct { int dmg; logic [31:0] vel; } expT;
  expT sbQ[$];

  int passCnt = 0, checkCnt = 0;
  int ackCnt = 0, pushCnt = 0, hsCycles = 0;
  int mdlDamage = 0;
  logic [31:0] mdlLastVel = '0;
  logic [31:0] velExp = '0;
  bit velPending = 0;

  int dmgT [1:10] = '{15, 14, 16, 16, 3, 8, 10, 9, 9, 6};
  int baseT[1:10] = '{6, 5, 6, 6, 1, 4, 3, 4, 4, 2};
  int dirT [1:10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4}; // 0 up 1 down 2 left 3 right 4 facing

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference velocity for attack idx at post-hit damage d.
  function automatic logic [31:0] mdlVel(input int idx, input int d, input bit f);
    int m, vx, vy;
    m = baseT[idx];
`ifdef KNOCKBACK_SCALE_EN
    m = m + (d >> 4);
    if (m > 127) m = 127;
`endif
    vx = 0; vy = 0;
    case (dirT[idx])
      0: vy = m;
      1: vy = -m;
      2: vx = -m;
      3: vx = m;
      default: begin vx = f ? m : -m; vy = m >> 1; end
    endcase
    return {vx[15:0], vy[15:0]};
  endfunction

  // Push the expected outcome of an accepted hit with word w.
  task automatic mdlHit(input logic [31:0] w);
    int idx;
    expT e;
    idx = 0;
    for (int i = 10; i >= 1; i--) if (w[i]) idx = i;
    mdlDamage = mdlDamage + dmgT[idx];
    if (mdlDamage > DMAX) mdlDamage = DMAX;
    e.dmg = mdlDamage;
    e.vel = mdlVel(idx, mdlDamage, attacker_facing);
    mdlLastVel = e.vel;
    sbQ.push_back(e);
    pushCnt++;
  endtask

  // Advance n cycles; each negedge pops the scoreboard on hit_ack.
  task automatic runCycles(input int n);
    expT e;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (velPending) begin
        chk("knock_vel", knock_vel, velExp);
        velPending = 0;
      end
      if (hitstun) hsCycles++;
      if (hit_ack) begin
        ackCnt++;
        if (sbQ.size() == 0) chk("hit_ack_unexpected", {31'b0, hit_ack}, 32'd0);
        else begin
          e = sbQ.pop_front();
          chk("damage", {16'b0, damage}, e.dmg);
          chk("ack_hitstun", {31'b0, hitstun}, 32'd1);
          velExp = e.vel;
          velPending = 1;
        end
      end
    end
  endtask

  task automatic doHit(input logic [31:0] w, input bit accept);
    attack = w;
    if (accept) mdlHit(w);
    runCycles(1);
    attack = '0;
    runCycles(1);
    chk("sb_drained", sbQ.size(), 0);
  endtask

  task automatic waitHitstunLow(input int bound);
    int k;
    k = 0;
    while (hitstun && k < bound) begin
      runCycles(1);
      k++;
    end
    chk("hitstun_timeout", {31'b0, hitstun}, 32'd0);
  endtask

  initial begin
    // Reset with a hit already asserted: counts as an edge on release.
    attacker_facing = 1'b1;
    attack = 32'h9;
    repeat (2) @(negedge clock);
    chk("rst_damage", {16'b0, damage}, 32'd0);
    chk("rst_vel", knock_vel, 32'd0);
    chk("rst_hitstun", {31'b0, hitstun}, 32'd0);
    chk("rst_ack", {31'b0, hit_ack}, 32'd0);
    mdlHit(32'h9);
    reset = 1'b1;
    runCycles(100);
    chk("one_hit", ackCnt, 32'd1);
    chk("hitstun_len", {31'b0, (hsCycles >= (HF-1)*FD + 2) && (hsCycles <= HF*FD + 1)}, 32'd1);
    chk("idle_vel", knock_vel, 32'd0);
    chk("idle_hitstun", {31'b0, hitstun}, 32'd0);
    attack = '0;
    runCycles(2);

    // bit0 with no type bit is ignored
    attack = 32'h1;
    runCycles(1);
    attack = '0;
    runCycles(3);
    chk("bit0_only_damage", {16'b0, damage}, mdlDamage);

    clear_damage = 1'b1;
    runCycles(1);
    clear_damage = 1'b0;
    mdlDamage = 0;
    chk("clear_damage", {16'b0, damage}, mdlDamage);

    // Jab, then decay to zero one tick after hitstun ends
    doHit(32'h21, 1);
    waitHitstunLow(40);
    chk("jab_decay_start", knock_vel, mdlLastVel);
    runCycles(FD - 1);
    chk("jab_decay_hold", knock_vel, mdlLastVel);
    runCycles(1);
    chk("jab_decayed", knock_vel, 32'd0);
    runCycles(3);

    // Priority: smash U beats smash R
    doHit(32'h13, 1);
    // Hit during HITSTUN is dropped
    attack = 32'h21;
    runCycles(1);
    attack = '0;
    runCycles(2);
    chk("stun_hit_damage", {16'b0, damage}, mdlDamage);
    waitHitstunLow(40);
    // Hit during DECAY replaces velocity (facing left)
    attacker_facing = 1'b0;
    doHit(32'h401, 1);
    waitHitstunLow(40);

    // Saturation with combo chain of smash R (upper bits ignored)
    clear_damage = 1'b1;
    runCycles(1);
    clear_damage = 1'b0;
    mdlDamage = 0;
    for (int i = 0; i < 63; i++) begin
      doHit(32'h8000_0011, 1);
      waitHitstunLow(40);
    end
    chk("sat_damage", {16'b0, damage}, 32'd999);
    chk("sat_vel", knock_vel, mdlLastVel);

    // clear_damage beats a simultaneous hit edge
    attack = 32'h11;
    clear_damage = 1'b1;
    runCycles(1);
    attack = '0;
    clear_damage = 1'b0;
    mdlDamage = 0;
    chk("conflict_damage", {16'b0, damage}, mdlDamage);
    chk("conflict_vel", knock_vel, 32'd0);
    chk("conflict_hitstun", {31'b0, hitstun}, 32'd0);
    runCycles(4);
    chk("ack_total", ackCnt, pushCnt);
    chk("sb_empty", sbQ.size(), 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
